mem_port_arbiter: RTL and testbench

// - Shares one single-port memory bus between instruction fetch (IF) and data access (MEM stage).
// - Sequences one transaction at a time and returns if_stall_o / d_stall_o to the hazard logic.
// - Squashes fetch responses on branch flush.
// - Sits between the pipeline front/back ends and the unified memory.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_port_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/MEM single-port memory bus arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } arb_state_e;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } owner_e;

    localparam logic [3:0] BE_WORD = 4'hF;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between instruction fetch and data access, one transaction at a time,
// with a starvation guard for fetch and squashing of flushed fetch responses.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned AW           = 32
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    input  logic          if_flush_i,
    output logic          if_rvalid_o,
    output logic [31:0]   if_rdata_o,
    output logic          if_stall_o,

    input  logic          d_req_i,
    input  logic          d_we_i,
    input  logic [3:0]    d_be_i,
    input  logic [AW-1:0] d_addr_i,
    input  logic [31:0]   d_wdata_i,
    output logic          d_rvalid_o,
    output logic [31:0]   d_rdata_o,
    output logic          d_stall_o,

    output logic          bus_req_o,
    output logic          bus_we_o,
    output logic [3:0]    bus_be_o,
    output logic [AW-1:0] bus_addr_o,
    output logic [31:0]   bus_wdata_o,
    input  logic          bus_gnt_i,
    input  logic          bus_rvalid_i,
    input  logic [31:0]   bus_rdata_i
);

    localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0] StreakMax = SW'(STARVE_LIMIT);

    arb_state_e    state_q, state_d;
    owner_e        owner_q, owner_d;
    logic          squash_q, squash_d;
    logic [SW-1:0] streak_q, streak_d;

    logic          bus_we_q, bus_we_d;
    logic [3:0]    bus_be_q, bus_be_d;
    logic [AW-1:0] bus_addr_q, bus_addr_d;
    logic [31:0]   bus_wdata_q, bus_wdata_d;

    logic if_eligible;
    logic starved;
    logic grant_if;
    logic grant_d;
    logic rsp_valid;

    // A flush in IDLE means the current fetch address is already stale.
    assign if_eligible = if_req_i && !if_flush_i;
    assign starved     = (streak_q == StreakMax);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        squash_d    = squash_q;
        streak_d    = streak_q;
        bus_we_d    = bus_we_q;
        bus_be_d    = bus_be_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        grant_if    = 1'b0;
        grant_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (if_eligible && (starved || !d_req_i)) begin
                    grant_if = 1'b1;
                end else if (d_req_i) begin
                    grant_d = 1'b1;
                end

                if (grant_if) begin
                    state_d     = REQ;
                    owner_d     = OWN_IF;
                    bus_we_d    = 1'b0;
                    bus_be_d    = BE_WORD;
                    bus_addr_d  = if_addr_i;
                    bus_wdata_d = '0;
                    streak_d    = '0;
                end else if (grant_d) begin
                    state_d     = REQ;
                    owner_d     = OWN_D;
                    bus_we_d    = d_we_i;
                    bus_be_d    = d_be_i;
                    bus_addr_d  = d_addr_i;
                    bus_wdata_d = d_wdata_i;
                    if (if_req_i && !starved) begin
                        streak_d = streak_q + 1'b1;
                    end
                end

                if (!if_req_i) begin
                    streak_d = '0;
                end
            end

            REQ: begin
                if (if_flush_i && owner_q == OWN_IF) begin
                    squash_d = 1'b1;
                end
                if (bus_gnt_i) begin
                    state_d = WAIT;
                end
            end

            WAIT: begin
                if (if_flush_i && owner_q == OWN_IF) begin
                    squash_d = 1'b1;
                end
                if (bus_rvalid_i) begin
                    state_d  = IDLE;
                    squash_d = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            squash_q    <= 1'b0;
            streak_q    <= '0;
            bus_we_q    <= 1'b0;
            bus_be_q    <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            squash_q    <= squash_d;
            streak_q    <= streak_d;
            bus_we_q    <= bus_we_d;
            bus_be_q    <= bus_be_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

    // Responses are only honoured while a transaction is outstanding.
    assign rsp_valid = (state_q == WAIT) && bus_rvalid_i;

    assign if_rvalid_o = rsp_valid && (owner_q == OWN_IF) && !squash_q && !if_flush_i;
    assign d_rvalid_o  = rsp_valid && (owner_q == OWN_D);
    assign if_rdata_o  = bus_rdata_i;
    assign d_rdata_o   = bus_rdata_i;

    assign if_stall_o = if_req_i && !if_rvalid_o;
    assign d_stall_o  = d_req_i && !d_rvalid_o;

    assign bus_req_o   = (state_q == REQ);
    assign bus_we_o    = bus_we_q;
    assign bus_be_o    = bus_be_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;

    a_no_gnt_with_rvalid: assert property (
        @(posedge clk) disable iff (rst)
        (state_q == REQ) |-> !(bus_gnt_i && bus_rvalid_i)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: directed requests push expected bus transactions and responses; a bus
// responder and a response monitor pop and compare independently.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gnt_delay;
        int          rsp_delay;
    } bus_txn_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          if_req_i, if_flush_i, if_rvalid_o, if_stall_o;
    logic [AW-1:0] if_addr_i;
    logic [31:0]   if_rdata_o;
    logic          d_req_i, d_we_i, d_rvalid_o, d_stall_o;
    logic [3:0]    d_be_i;
    logic [AW-1:0] d_addr_i;
    logic [31:0]   d_wdata_i, d_rdata_o;
    logic          bus_req_o, bus_we_o, bus_gnt_i, bus_rvalid_i;
    logic [3:0]    bus_be_o;
    logic [AW-1:0] bus_addr_o;
    logic [31:0]   bus_wdata_o, bus_rdata_i;

    bus_txn_t    bus_q[$];
    logic [31:0] if_q[$];
    logic [31:0] d_q[$];
    logic        slave_en;
    int          n_checks = 0;
    int          n_fail   = 0;

    mem_port_arbiter #(
        .STARVE_LIMIT (4),
        .AW           (AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req_i     (if_req_i),
        .if_addr_i    (if_addr_i),
        .if_flush_i   (if_flush_i),
        .if_rvalid_o  (if_rvalid_o),
        .if_rdata_o   (if_rdata_o),
        .if_stall_o   (if_stall_o),
        .d_req_i      (d_req_i),
        .d_we_i       (d_we_i),
        .d_be_i       (d_be_i),
        .d_addr_i     (d_addr_i),
        .d_wdata_i    (d_wdata_i),
        .d_rvalid_o   (d_rvalid_o),
        .d_rdata_o    (d_rdata_o),
        .d_stall_o    (d_stall_o),
        .bus_req_o    (bus_req_o),
        .bus_we_o     (bus_we_o),
        .bus_be_o     (bus_be_o),
        .bus_addr_o   (bus_addr_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_gnt_i    (bus_gnt_i),
        .bus_rvalid_i (bus_rvalid_i),
        .bus_rdata_i  (bus_rdata_i)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    function automatic bus_txn_t mk(input logic [31:0] a, input logic we, input logic [3:0] be,
                                    input logic [31:0] wd, input logic [31:0] rd,
                                    input int gd, input int rdl);
        bus_txn_t t;
        t.addr = a; t.we = we; t.be = be; t.wdata = wd; t.rdata = rd;
        t.gnt_delay = gd; t.rsp_delay = rdl;
        return t;
    endfunction

    // Bus responder: checks each issued transaction against the expected order and payload.
    initial begin
        bus_txn_t t;
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b0;
        bus_rdata_i  = '0;
        forever begin
            @(posedge clk); #1;
            if (slave_en && bus_req_o) begin
                if (bus_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL bus_unexpected_req: got addr 0x%08h required no request",
                             bus_addr_o);
                    bus_gnt_i = 1'b1;
                    @(posedge clk); #1;
                    bus_gnt_i    = 1'b0;
                    bus_rvalid_i = 1'b1;
                    @(posedge clk); #1;
                    bus_rvalid_i = 1'b0;
                end else begin
                    t = bus_q.pop_front();
                    check("bus_addr", bus_addr_o, t.addr);
                    check("bus_we", bus_we_o, t.we);
                    check("bus_be", bus_be_o, t.be);
                    if (t.we) check("bus_wdata", bus_wdata_o, t.wdata);
                    repeat (t.gnt_delay) begin
                        @(posedge clk); #1;
                        check("bus_req_held", bus_req_o, 1);
                        check("bus_addr_held", bus_addr_o, t.addr);
                        check("bus_we_held", bus_we_o, t.we);
                        check("bus_be_held", bus_be_o, t.be);
                    end
                    bus_gnt_i = 1'b1;
                    @(posedge clk); #1;
                    bus_gnt_i = 1'b0;
                    repeat (t.rsp_delay - 1) begin
                        @(posedge clk); #1;
                    end
                    bus_rvalid_i = 1'b1;
                    bus_rdata_i  = t.rdata;
                    @(posedge clk); #1;
                    bus_rvalid_i = 1'b0;
                end
            end
        end
    end

    // Response monitor.
    initial begin
        logic [31:0] exp;
        forever begin
            @(negedge clk);
            if (if_rvalid_o) begin
                if (if_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL if_rvalid_unexpected: got 1 required 0");
                end else begin
                    exp = if_q.pop_front();
                    check("if_rdata", if_rdata_o, exp);
                    check("if_stall_on_rvalid", if_stall_o, 0);
                end
            end
            if (d_rvalid_o) begin
                if (d_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL d_rvalid_unexpected: got 1 required 0");
                end else begin
                    exp = d_q.pop_front();
                    check("d_rdata", d_rdata_o, exp);
                    check("d_stall_on_rvalid", d_stall_o, 0);
                    check("if_stall_during_d_rvalid", if_stall_o, if_req_i);
                end
            end
        end
    end

    task automatic fetch(input logic [31:0] a, input logic [31:0] rd);
        int n;
        if_q.push_back(rd);
        if_req_i  = 1'b1;
        if_addr_i = a;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!if_rvalid_o && n < 200);
        check("if_rvalid_seen", if_rvalid_o, 1);
        @(posedge clk); #1;
        if_req_i = 1'b0;
    endtask

    task automatic d_access(input logic we, input logic [3:0] be, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rd);
        int n;
        d_q.push_back(rd);
        d_req_i   = 1'b1;
        d_we_i    = we;
        d_be_i    = be;
        d_addr_i  = a;
        d_wdata_i = wd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!d_rvalid_o && n < 200);
        check("d_rvalid_seen", d_rvalid_o, 1);
        @(posedge clk); #1;
        d_req_i = 1'b0;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        slave_en = 1'b1;
        if_req_i = 1'b0; if_addr_i = '0; if_flush_i = 1'b0;
        d_req_i = 1'b0; d_we_i = 1'b0; d_be_i = '0; d_addr_i = '0; d_wdata_i = '0;

        // Reset state
        idle(3);
        @(negedge clk);
        check("rst_bus_req", bus_req_o, 0);
        check("rst_bus_we", bus_we_o, 0);
        check("rst_bus_be", bus_be_o, 0);
        check("rst_bus_addr", bus_addr_o, 0);
        check("rst_bus_wdata", bus_wdata_o, 0);
        check("rst_if_rvalid", if_rvalid_o, 0);
        check("rst_d_rvalid", d_rvalid_o, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // 1: lone fetch, cycle-accurate latency
        bus_q.push_back(mk(32'h100, 1'b0, 4'hF, 32'h0, 32'hDEADBEEF, 0, 1));
        if_q.push_back(32'hDEADBEEF);
        if_req_i  = 1'b1;
        if_addr_i = 32'h100;
        @(negedge clk);
        check("t1_stall_n", if_stall_o, 1);
        check("t1_bus_req_n", bus_req_o, 0);
        @(negedge clk);
        check("t1_stall_n1", if_stall_o, 1);
        check("t1_bus_req_n1", bus_req_o, 1);
        @(negedge clk);
        check("t1_rvalid_n2", if_rvalid_o, 1);
        check("t1_rdata_n2", if_rdata_o, 32'hDEADBEEF);
        @(posedge clk); #1;
        if_req_i = 1'b0;
        idle(3);

        // 2: simultaneous fetch and load, data first
        bus_q.push_back(mk(32'h200, 1'b0, 4'hF, 32'h0, 32'hA0A0A0A0, 0, 1));
        bus_q.push_back(mk(32'h104, 1'b0, 4'hF, 32'h0, 32'hB1B1B1B1, 0, 1));
        fork
            fetch(32'h104, 32'hB1B1B1B1);
            begin
                d_q.push_back(32'hA0A0A0A0);
                d_req_i = 1'b1; d_we_i = 1'b0; d_be_i = 4'hF; d_addr_i = 32'h200;
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!d_rvalid_o && n < 200);
                check("t2_d_rvalid_seen", d_rvalid_o, 1);
                check("t2_d_stall", d_stall_o, 0);
                check("t2_if_stall", if_stall_o, 1);
                @(posedge clk); #1;
                d_req_i = 1'b0;
            end
        join
        idle(3);

        // 3: starvation guard, IF wins the 5th grant
        for (int i = 0; i < 4; i++) begin
            bus_q.push_back(mk(32'h600 + 4 * i, 1'b0, 4'hF, 32'h0, 32'h6000_0000 + i, 0, 1));
        end
        bus_q.push_back(mk(32'h500, 1'b0, 4'hF, 32'h0, 32'h5555AAAA, 0, 1));
        for (int i = 4; i < 6; i++) begin
            bus_q.push_back(mk(32'h600 + 4 * i, 1'b0, 4'hF, 32'h0, 32'h6000_0000 + i, 0, 1));
        end
        fork
            fetch(32'h500, 32'h5555AAAA);
            for (int i = 0; i < 6; i++) begin
                d_access(1'b0, 4'hF, 32'h600 + 4 * i, 32'h0, 32'h6000_0000 + i);
            end
        join
        idle(3);

        // 4: store with gnt held low for three cycles
        bus_q.push_back(mk(32'h204, 1'b1, 4'b0011, 32'h1234, 32'h0, 3, 1));
        d_access(1'b1, 4'b0011, 32'h204, 32'h1234, 32'h0);
        idle(3);

        // 5: flush during fetch WAIT squashes the response
        bus_q.push_back(mk(32'h400, 1'b0, 4'hF, 32'h0, 32'h11111111, 0, 3));
        if_req_i  = 1'b1;
        if_addr_i = 32'h400;
        idle(2);
        if_flush_i = 1'b1;
        if_req_i   = 1'b0;
        idle(1);
        if_flush_i = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus_rvalid_i && n < 50);
        check("t5_bus_completes", bus_rvalid_i, 1);
        check("t5_if_rvalid_squashed", if_rvalid_o, 0);
        idle(2);
        bus_q.push_back(mk(32'h404, 1'b0, 4'hF, 32'h0, 32'h22222222, 0, 1));
        fetch(32'h404, 32'h22222222);
        idle(3);

        // 6: reset mid-WAIT, stray response afterwards
        slave_en = 1'b0;
        d_req_i = 1'b1; d_we_i = 1'b0; d_be_i = 4'hF; d_addr_i = 32'h300;
        idle(1);
        bus_gnt_i = 1'b1;
        @(negedge clk);
        check("t6_bus_req", bus_req_o, 1);
        @(posedge clk); #1;
        bus_gnt_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("t6_d_stall_wait", d_stall_o, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        d_req_i = 1'b0;
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'hBADBAD00;
        @(negedge clk);
        check("t6_bus_req_after_rst", bus_req_o, 0);
        check("t6_bus_addr_after_rst", bus_addr_o, 0);
        check("t6_d_rvalid_stray", d_rvalid_o, 0);
        check("t6_if_rvalid_stray", if_rvalid_o, 0);
        @(posedge clk); #1;
        bus_rvalid_i = 1'b0;
        @(negedge clk);
        check("t6_bus_req_idle", bus_req_o, 0);
        idle(2);

        check("bus_q_drained", bus_q.size(), 0);
        check("if_q_drained", if_q.size(), 0);
        check("d_q_drained", d_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
